fetch_unit: RTL

//  Sequences the instruction memory for the rv32i core: owns the PC, drives the word-aligned read

---
 rtl/rv32_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32i core types: data widths, canonical NOP, fetch FSM states and fault codes.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_RANGE    = 2'd2
  } fault_cause_e;
endpackage

// File: rtl/fetch_fifo.sv
// Sync prefetch FIFO with registered head; a write is visible at the head one cycle later.
// Push into a full FIFO is accepted only alongside a pop; flush overrides push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push, do_pop;

  assign do_pop     = pop && (count != '0) && !flush;
  assign do_push    = push && ((count < FULL) || do_pop) && !flush;
  assign head_valid = (count != '0);

  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    head_nxt  = head_data;
    if (flush) begin
      rd_nxt    = '0;
      wr_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (do_pop)  rd_nxt = rd_ptr + AW'(1);
      if (do_push) wr_nxt = wr_ptr + AW'(1);
      count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // Head register tracks the next head; a same-cycle write bypasses the array.
    if (count_nxt != '0)
      head_nxt = (do_push && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= count_nxt;
      head_data <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem combinationally and queues {pc, instr} for decode.
// One-cycle fetch-to-decode latency; stalls fetch when the prefetch FIFO is full and not popping.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              IMEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic            fault,
  output logic [1:0]      fault_cause
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

  fetch_state_e           state_q, state_nxt;
  fault_cause_e           cause_q;
  logic [XLEN-1:0]        pc_q;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_push, fifo_pop, fifo_flush;
  logic                   head_valid;
  logic [XLEN+ILEN-1:0]   head_data;
  logic                   redirect_ok, misalign, space, try_fetch, out_of_range;

  // Redirects are ignored once faulted so the faulting PC stays visible.
  assign redirect_ok  = redirect_valid && (state_q != FAULT);
  assign misalign     = redirect_ok && (redirect_pc[1:0] != 2'b00);
  assign fifo_pop     = head_valid && out_ready;
  assign space        = (fifo_count < CW'(FIFO_DEPTH)) || fifo_pop;
  assign try_fetch    = (state_q == RUN) && fetch_en && !redirect_valid && space;
  assign out_of_range = try_fetch && (pc_q >= PC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN: begin
        if (misalign)                          state_nxt = FAULT;
        else if (out_of_range)                 state_nxt = FAULT;
        else if (!fetch_en && !redirect_valid) state_nxt = HALT;
      end
      HALT: begin
        if (misalign)      state_nxt = FAULT;
        else if (fetch_en) state_nxt = RUN;
      end
      default: state_nxt = FAULT;
    endcase
  end

  always_comb begin
    fifo_push  = try_fetch && !out_of_range;
    fifo_flush = redirect_ok;
    fault      = (state_q == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      cause_q <= FC_NONE;
    end else begin
      if (redirect_ok)    pc_q <= redirect_pc;
      else if (fifo_push) pc_q <= pc_q + 32'd4;
      if (misalign)          cause_q <= FC_MISALIGN;
      else if (out_of_range) cause_q <= FC_RANGE;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  ({pc_q, imem_rdata}),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign imem_addr   = pc_q;
  assign out_valid   = head_valid;
  assign out_pc      = head_data[XLEN+ILEN-1:ILEN];
  assign out_instr   = head_data[ILEN-1:0];
  assign fault_cause = cause_q;
endmodule
